// File: rtl/pwr_seq_if.sv
// Signal bundle between pwr_seq and the board/CPU side: button and power-fail
// acknowledge in, DCLO/ACLO plus debug state and debounced level out.
interface pwr_seq_if;
  // No valid/ready pair here: rstin and pf_done are plain levels sampled on every
  // clk edge, and the outputs are registered levels. Nothing waits on a handshake.
  logic       rstin;
  logic       pf_done;
  logic       dclo;
  logic       aclo;
  logic       pwr_ok;
  logic [2:0] state;

  modport master (
    output rstin,
    output pf_done,
    input  dclo,
    input  aclo,
    input  pwr_ok,
    input  state
  );

  modport slave (
    input  rstin,
    input  pf_done,
    output dclo,
    output aclo,
    output pwr_ok,
    output state
  );
endinterface

// File: rtl/pwr_seq.sv
// Q-bus power sequencer: debounces the reset button and runs the ordered
// DCLO/ACLO power-up, power-fail and abort sequences.
module pwr_seq #(
    parameter int DEBOUNCE_CLK   = 1000000,
    parameter int DCLO_MIN_CLK   = 5,
    parameter int ACLO_DELAY_CLK = 150000,
    parameter int ACLO_LEAD_CLK  = 100000,
    parameter int CNT_W          = 24
) (
    input logic      clk,
    input logic      reset,
    pwr_seq_if.slave bus
);

    typedef enum logic [2:0] {
        S_DOWN  = 3'd0,
        S_UPDLY = 3'd1,
        S_RUN   = 3'd2,
        S_PFAIL = 3'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CLK - 1);
    localparam logic [CNT_W-1:0] DCLO_MIN   = CNT_W'(DCLO_MIN_CLK);
    localparam logic [CNT_W-1:0] UPDLY_LAST = CNT_W'(ACLO_DELAY_CLK - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(ACLO_LEAD_CLK - 1);

    logic             s1;
    logic             s2;
    logic             pwr_ok_q;
    logic [CNT_W-1:0] db_cnt;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dclo_q;
    logic             dclo_d;
    logic             aclo_q;
    logic             aclo_d;

    // Button conditioning: pwr_ok only follows s2 after it has differed for a full window.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            pwr_ok_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            s1 <= bus.rstin;
            s2 <= s1;
            if (s2 == pwr_ok_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                pwr_ok_q <= s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_DOWN;
            cnt_q   <= '0;
            dclo_q  <= 1'b1;
            aclo_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dclo_q  <= dclo_d;
            aclo_q  <= aclo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dclo_d  = 1'b1;
        aclo_d  = 1'b1;

        case (state_q)
            S_DOWN: begin
                if (cnt_q == DCLO_MIN && pwr_ok_q) begin
                    state_d = S_UPDLY;
                end else if (cnt_q != DCLO_MIN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UPDLY: begin
                // Losing power mid power-up wins even on the final delay cycle.
                if (!pwr_ok_q) begin
                    state_d = S_DOWN;
                end else if (cnt_q == UPDLY_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!pwr_ok_q) begin
                    state_d = S_PFAIL;
                end
            end
            S_PFAIL: begin
                // pwr_ok is deliberately ignored here: a started power-fail always completes.
                if (bus.pf_done) begin
                    state_d = S_DOWN;
                end else if (cnt_q == LEAD_LAST) begin
                    state_d = S_DOWN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_DOWN;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Outputs are decoded from the next state so they switch on the same edge.
        dclo_d = (state_d == S_DOWN);
        aclo_d = (state_d != S_RUN);
    end

    assign bus.state  = state_q;
    assign bus.dclo   = dclo_q;
    assign bus.aclo   = aclo_q;
    assign bus.pwr_ok = pwr_ok_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Directed bench for pwr_seq: the driver queues timestamped output changes,
// the monitor compares every observed output change against the queue head.
module tb_pwr_seq;

  localparam int W = 22;  // {cycle[15:0], state[2:0], dclo, aclo, pwr_ok}

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  logic [W-1:0] exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic         end_req  = 1'b0;
  logic [5:0]   prev     = '1;
  logic [5:0]   cur;
  logic [W-1:0] got;
  logic [W-1:0] e;

  pwr_seq_if bus();

  pwr_seq #(
    .DEBOUNCE_CLK  (4),
    .DCLO_MIN_CLK  (5),
    .ACLO_DELAY_CLK(3),
    .ACLO_LEAD_CLK (10),
    .CNT_W         (24)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required end before", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_ev(input int c, input logic [2:0] st, input logic d, input logic a,
                         input logic p);
    exp_q.push_back({16'(c), st, d, a, p});
  endtask

  // Advance to just after edge number c; inputs set afterwards are seen at edge c+1.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    cur = {bus.state, bus.dclo, bus.aclo, bus.pwr_ok};
    if (cur !== prev) begin
      got = {16'(cyc), cur};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event: got cyc=%0d state=%0d dclo=%b aclo=%b pwr_ok=%b, required no change",
                 cyc, cur[5:3], cur[2], cur[1], cur[0]);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL event: got cyc=%0d state=%0d dclo=%b aclo=%b pwr_ok=%b, required cyc=%0d state=%0d dclo=%b aclo=%b pwr_ok=%b",
                   got[21:6], got[5:3], got[2], got[1], got[0],
                   e[21:6], e[5:3], e[2], e[1], e[0]);
        end
      end
      prev = cur;
    end
    if (end_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_events: got %0d still pending, required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  // driver
  initial begin
    int s;
    int r;
    bus.rstin   = 1'b1;
    bus.pf_done = 1'b0;
    reset       = 1'b1;

    // reset state, then power-up: pwr_ok at +6, dclo low at +7, aclo low at +10
    push_ev(1, 3'd0, 1'b1, 1'b1, 1'b0);
    goto(3);
    reset = 1'b0;
    s = 3;
    push_ev(s + 6,  3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(s + 7,  3'd1, 1'b0, 1'b1, 1'b1);
    push_ev(s + 10, 3'd2, 1'b0, 1'b0, 1'b1);
    goto(s + 12);

    // 3-cycle glitch in RUN: no output may change
    s = cyc;
    bus.rstin = 1'b0;
    goto(s + 3);
    bus.rstin = 1'b1;
    goto(s + 12);

    // timed power fail, button back during PFAIL, then abort inside UPDLY
    s = cyc;
    bus.rstin = 1'b0;
    push_ev(s + 6, 3'd2, 1'b0, 1'b0, 1'b0);
    push_ev(s + 7, 3'd3, 1'b0, 1'b1, 1'b0);
    goto(s + 7);
    bus.rstin = 1'b1;
    push_ev(s + 13, 3'd3, 1'b0, 1'b1, 1'b1);
    push_ev(s + 17, 3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(s + 23, 3'd1, 1'b0, 1'b1, 1'b1);
    goto(s + 18);
    bus.rstin = 1'b0;
    push_ev(s + 24, 3'd1, 1'b0, 1'b1, 1'b0);
    push_ev(s + 25, 3'd0, 1'b1, 1'b1, 1'b0);
    goto(s + 27);
    r = cyc;
    bus.rstin = 1'b1;
    push_ev(r + 6,  3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(r + 7,  3'd1, 1'b0, 1'b1, 1'b1);
    push_ev(r + 10, 3'd2, 1'b0, 1'b0, 1'b1);
    goto(r + 12);

    // early exit: pf_done 4 cycles after aclo rises
    s = cyc;
    bus.rstin = 1'b0;
    push_ev(s + 6, 3'd2, 1'b0, 1'b0, 1'b0);
    push_ev(s + 7, 3'd3, 1'b0, 1'b1, 1'b0);
    goto(s + 11);
    bus.pf_done = 1'b1;
    push_ev(s + 12, 3'd0, 1'b1, 1'b1, 1'b0);
    goto(s + 12);
    bus.pf_done = 1'b0;
    bus.rstin   = 1'b1;
    push_ev(s + 18, 3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(s + 19, 3'd1, 1'b0, 1'b1, 1'b1);
    push_ev(s + 22, 3'd2, 1'b0, 1'b0, 1'b1);
    goto(s + 24);

    // pf_done coinciding with the last lead cycle: one transition only
    s = cyc;
    bus.rstin = 1'b0;
    push_ev(s + 6, 3'd2, 1'b0, 1'b0, 1'b0);
    push_ev(s + 7, 3'd3, 1'b0, 1'b1, 1'b0);
    goto(s + 16);
    bus.pf_done = 1'b1;
    push_ev(s + 17, 3'd0, 1'b1, 1'b1, 1'b0);
    goto(s + 17);
    bus.pf_done = 1'b0;
    bus.rstin   = 1'b1;
    push_ev(s + 23, 3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(s + 24, 3'd1, 1'b0, 1'b1, 1'b1);
    push_ev(s + 27, 3'd2, 1'b0, 1'b0, 1'b1);
    goto(s + 29);

    // reset pulsed in PFAIL
    s = cyc;
    bus.rstin = 1'b0;
    push_ev(s + 6, 3'd2, 1'b0, 1'b0, 1'b0);
    push_ev(s + 7, 3'd3, 1'b0, 1'b1, 1'b0);
    goto(s + 9);
    reset     = 1'b1;
    bus.rstin = 1'b1;
    push_ev(s + 10, 3'd0, 1'b1, 1'b1, 1'b0);
    goto(s + 10);
    reset = 1'b0;
    push_ev(s + 16, 3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(s + 17, 3'd1, 1'b0, 1'b1, 1'b1);
    push_ev(s + 20, 3'd2, 1'b0, 1'b0, 1'b1);
    goto(s + 22);

    // reset pulsed in RUN
    s = cyc;
    reset = 1'b1;
    push_ev(s + 1, 3'd0, 1'b1, 1'b1, 1'b0);
    goto(s + 1);
    reset = 1'b0;
    push_ev(s + 7,  3'd0, 1'b1, 1'b1, 1'b1);
    push_ev(s + 8,  3'd1, 1'b0, 1'b1, 1'b1);
    push_ev(s + 11, 3'd2, 1'b0, 1'b0, 1'b1);
    goto(s + 14);

    end_req = 1'b1;
  end

endmodule
